// File: rtl/pio_gpio_irq.sv
// Avalon-MM GPIO: synchronised inputs, edge-capture interrupt, set/clear outputs.
// Define PIO_GPIO_DEBOUNCE_EN to build the per-bit input debounce counters.
module pio_gpio_irq #(
  parameter int IN_WIDTH        = 4,
  parameter int OUT_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  sw_in,
  output logic [OUT_WIDTH-1:0] led_out,
  output logic                 irq
);

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

  logic [IN_WIDTH-1:0]  sync_q1;
  logic [IN_WIDTH-1:0]  sync_q2;
  logic [IN_WIDTH-1:0]  deb;
  logic [IN_WIDTH-1:0]  deb_prev;
  logic [IN_WIDTH-1:0]  edge_hit;
  logic [IN_WIDTH-1:0]  edge_cap;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [IN_WIDTH-1:0]  cap_clr;
  logic [OUT_WIDTH-1:0] data_out;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  assign unused_wdata = ^avs_writedata;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sw_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PIO_GPIO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0][CNT_W-1:0] db_cnt;

  // Counter only runs while the synced bit disagrees with the debounced bit.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      db_cnt <= '0;
      deb    <= '0;
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (sync_q2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          deb[i]    <= sync_q2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign deb = sync_q2;
`endif

  always_comb begin
    case (EDGE_MODE)
      0:       edge_hit = deb & ~deb_prev;
      1:       edge_hit = ~deb & deb_prev;
      default: edge_hit = deb ^ deb_prev;
    endcase
  end

  always_comb begin
    cap_clr = '0;
    if (avs_write && avs_address == ADDR_EDGE_CAP) cap_clr = avs_writedata[IN_WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA_IN:  rd_mux[IN_WIDTH-1:0]  = deb;
      ADDR_DATA_OUT: rd_mux[OUT_WIDTH-1:0] = data_out;
      ADDR_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask;
      ADDR_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap;
      default:       rd_mux = '0;
    endcase
  end

  // A fresh edge wins over a write-1-clear landing on the same bit.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      deb_prev     <= '0;
      edge_cap     <= '0;
      irq_mask     <= '0;
      data_out     <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      deb_prev     <= deb;
      edge_cap     <= (edge_cap & ~cap_clr) | edge_hit;
      irq          <= |(edge_cap & irq_mask);
      avs_readdata <= avs_read ? rd_mux : '0;
      if (avs_write) begin
        case (avs_address)
          ADDR_DATA_OUT: data_out <= avs_writedata[OUT_WIDTH-1:0];
          ADDR_IRQ_MASK: irq_mask <= avs_writedata[IN_WIDTH-1:0];
          ADDR_OUT_SET:  data_out <= data_out | avs_writedata[OUT_WIDTH-1:0];
          ADDR_OUT_CLR:  data_out <= data_out & ~avs_writedata[OUT_WIDTH-1:0];
          default:       data_out <= data_out;
        endcase
      end
    end
  end

  assign led_out = data_out;

endmodule

// File: tb/tb_pio_gpio_irq.sv
// Bench for pio_gpio_irq: one instance per edge mode sharing all stimulus,
// register table, directed corner sequences and randomized run against a model.
module tb_pio_gpio_irq;
  localparam int IW = 4;
  localparam int OW = 4;
  localparam int DB = 8;
`ifdef PIO_GPIO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int LAT = DEB_EN ? 2 + DB : 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_r   = 1'b1;
  logic          rd_r    = 1'b0;
  logic          wr_r    = 1'b0;
  logic [2:0]    addr_r  = '0;
  logic [31:0]   wdata_r = '0;
  logic [IW-1:0] sw_r    = '0;

  logic [2:0][31:0]   rdata;
  logic [2:0][OW-1:0] led;
  logic [2:0]         irq_o;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pio_gpio_irq #(
      .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(g)
    ) dut (
      .clk_clk(clk),
      .reset_reset(rst_r),
      .avs_address(addr_r),
      .avs_read(rd_r),
      .avs_write(wr_r),
      .avs_writedata(wdata_r),
      .avs_readdata(rdata[g]),
      .sw_in(sw_r),
      .led_out(led[g]),
      .irq(irq_o[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [IW-1:0] m_sh1, m_sh2, m_deb, m_prev, m_mask;
  logic [IW-1:0] m_cap [3];
  logic [OW-1:0] m_out;
  logic          m_irq [3];
  int            m_run [IW];

  function automatic logic [IW-1:0] edges(int mode, logic [IW-1:0] now, logic [IW-1:0] prev);
    if (mode == 0) return now & ~prev;
    if (mode == 1) return ~now & prev;
    return now ^ prev;
  endfunction

  task automatic tick();
    logic [31:0]   exp_rd [3];
    logic [IW-1:0] deb_now, clr;
    bit            did_rd, in_rst;
    did_rd = rd_r;
    in_rst = rst_r;
    if (rst_r) begin
      m_sh1 = '0; m_sh2 = '0; m_deb = '0; m_prev = '0; m_mask = '0; m_out = '0;
      for (int i = 0; i < IW; i++) m_run[i] = 0;
      for (int m = 0; m < 3; m++) begin
        m_cap[m] = '0; m_irq[m] = 1'b0; exp_rd[m] = '0;
      end
    end else begin
      deb_now = DEB_EN ? m_deb : m_sh2;
      clr = (wr_r && addr_r == 3'd3) ? wdata_r[IW-1:0] : '0;
      for (int m = 0; m < 3; m++) begin
        case (addr_r)
          3'd0:    exp_rd[m] = 32'(deb_now);
          3'd1:    exp_rd[m] = 32'(m_out);
          3'd2:    exp_rd[m] = 32'(m_mask);
          3'd3:    exp_rd[m] = 32'(m_cap[m]);
          default: exp_rd[m] = '0;
        endcase
        m_irq[m] = |(m_cap[m] & m_mask);
        m_cap[m] = (m_cap[m] & ~clr) | edges(m, deb_now, m_prev);
      end
      m_prev = deb_now;
      // A bit flips once DB consecutive synced samples disagree with it
      if (DEB_EN) begin
        for (int i = 0; i < IW; i++) begin
          if (m_sh2[i] == m_deb[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == DB) begin
              m_deb[i] = m_sh2[i];
              m_run[i] = 0;
            end
          end
        end
      end
      if (wr_r) begin
        case (addr_r)
          3'd1: m_out = wdata_r[OW-1:0];
          3'd2: m_mask = wdata_r[IW-1:0];
          3'd4: m_out = m_out | wdata_r[OW-1:0];
          3'd5: m_out = m_out & ~wdata_r[OW-1:0];
          default: ;
        endcase
      end
      m_sh2 = m_sh1;
      m_sh1 = sw_r;
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("model led m%0d", m), 32'(led[m]), 32'(m_out));
      chk($sformatf("model irq m%0d", m), 32'(irq_o[m]), 32'(m_irq[m]));
      if (in_rst) chk($sformatf("reset readdata m%0d", m), rdata[m], 32'h0);
      else if (did_rd) chk($sformatf("model rd a%0d m%0d", addr_r, m), rdata[m], exp_rd[m]);
    end
  endtask

  task automatic idle(int n);
    rd_r = 1'b0; wr_r = 1'b0;
    repeat (n) tick();
  endtask

  task automatic bus_wr(logic [2:0] a, logic [31:0] d);
    rd_r = 1'b0; wr_r = 1'b1; addr_r = a; wdata_r = d;
    tick();
    wr_r = 1'b0;
  endtask

  task automatic bus_rd(logic [2:0] a);
    rd_r = 1'b1; wr_r = 1'b0; addr_r = a;
    tick();
    rd_r = 1'b0;
  endtask

  // Expected readdata per edge mode (0 rising, 1 falling, 2 both)
  task automatic chk_rd3(string name, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
    chk({name, " m0"}, rdata[0], e0);
    chk({name, " m1"}, rdata[1], e1);
    chk({name, " m2"}, rdata[2], e2);
  endtask

  task automatic chk_irq3(string name, logic e0, logic e1, logic e2);
    chk({name, " m0"}, 32'(irq_o[0]), 32'(e0));
    chk({name, " m1"}, 32'(irq_o[1]), 32'(e1));
    chk({name, " m2"}, 32'(irq_o[2]), 32'(e2));
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [OW-1:0] exp_led;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(bit rd, bit wr, logic [2:0] a, logic [31:0] d,
                              logic [OW-1:0] el, bit cr, logic [31:0] er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
    v.exp_led = el; v.chk_rd = cr; v.exp_rd = er;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   hold;

    for (int a = 0; a < 8; a++) vecs.push_back(mk(1, 0, 3'(a), 0, 4'h0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 3'd1, 32'hA, 4'hA, 0, 0));
    vecs.push_back(mk(0, 1, 3'd4, 32'h1, 4'hB, 0, 0));
    vecs.push_back(mk(0, 1, 3'd5, 32'h8, 4'h3, 0, 0));
    vecs.push_back(mk(1, 0, 3'd1, 32'h0, 4'h3, 1, 32'h3));
    vecs.push_back(mk(1, 1, 3'd1, 32'hFFFF_FFF5, 4'h5, 1, 32'h3));
    vecs.push_back(mk(1, 0, 3'd1, 32'h0, 4'h5, 1, 32'h5));
    vecs.push_back(mk(0, 1, 3'd5, 32'hFFFF_FFFF, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 3'd4, 32'h0, 4'h0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 3'd2, 32'hFFFF_FFF1, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 3'd2, 32'h0, 4'h0, 1, 32'h1));

    rst_r = 1'b1;
    idle(3);
    for (int m = 0; m < 3; m++) chk($sformatf("reset led m%0d", m), 32'(led[m]), 32'h0);
    chk_irq3("reset irq", 1'b0, 1'b0, 1'b0);
    rst_r = 1'b0;

    foreach (vecs[k]) begin
      rd_r = vecs[k].rd; wr_r = vecs[k].wr; addr_r = vecs[k].addr; wdata_r = vecs[k].wdata;
      tick();
      rd_r = 1'b0; wr_r = 1'b0;
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("vec%0d led m%0d", k, m), 32'(led[m]), 32'(vecs[k].exp_led));
        if (vecs[k].chk_rd) chk($sformatf("vec%0d rd m%0d", k, m), rdata[m], vecs[k].exp_rd);
      end
    end

`ifdef PIO_GPIO_DEBOUNCE_EN
    sw_r = 4'h1;
    idle(5);
    sw_r = 4'h0;
    idle(LAT + 2);
    bus_rd(3'd0);
    chk_rd3("glitch data_in", 0, 0, 0);
    bus_rd(3'd3);
    chk_rd3("glitch edge_cap", 0, 0, 0);
`endif

    // Rising edge on bit 0: exact latency, capture, irq, then clear
    sw_r = 4'h1;
    idle(LAT - 1);
    bus_rd(3'd0);
    chk_rd3("data_in before latency", 0, 0, 0);
    bus_rd(3'd0);
    chk_rd3("data_in at latency", 1, 1, 1);
    bus_rd(3'd3);
    chk_rd3("rise edge_cap", 1, 0, 1);
    chk_irq3("rise irq", 1'b1, 1'b0, 1'b1);
    bus_wr(3'd3, 32'h1);
    idle(1);
    chk_irq3("irq after w1c", 1'b0, 1'b0, 1'b0);
    bus_rd(3'd3);
    chk_rd3("edge_cap after w1c", 0, 0, 0);

    // Falling edge on bit 0
    sw_r = 4'h0;
    idle(LAT + 1);
    bus_rd(3'd3);
    chk_rd3("fall edge_cap", 0, 1, 1);
    chk_irq3("fall irq", 1'b0, 1'b1, 1'b1);
    bus_wr(3'd3, 32'hF);
    idle(1);
    bus_rd(3'd3);
    chk_rd3("edge_cap cleared", 0, 0, 0);

    // Write-1-clear colliding with a new bit-2 edge; bit 2 is not masked
    sw_r = 4'h4;
    idle(LAT);
    bus_wr(3'd3, 32'h4);
    bus_rd(3'd3);
    chk_rd3("w1c vs edge", 32'h4, 32'h0, 32'h4);
    chk_irq3("unmasked edge irq", 1'b0, 1'b0, 1'b0);
    sw_r = 4'h0;
    idle(LAT + 2);
    bus_wr(3'd3, 32'hF);
    idle(1);

    // Reset mid-debounce, input held high through release
    sw_r = 4'h2;
    idle(LAT - 2);
    rst_r = 1'b1;
    tick();
    for (int m = 0; m < 3; m++) chk($sformatf("mid reset led m%0d", m), 32'(led[m]), 32'h0);
    rst_r = 1'b0;
    idle(LAT - 1);
    bus_rd(3'd0);
    chk_rd3("post reset data_in early", 0, 0, 0);
    bus_rd(3'd0);
    chk_rd3("post reset data_in", 2, 2, 2);
    bus_rd(3'd3);
    chk_rd3("post reset edge", 2, 0, 2);

    // Randomized run against the model
    hold = 1;
    for (int n = 0; n < 1500; n++) begin
      hold--;
      if (hold == 0) begin
        sw_r = IW'($urandom);
        hold = $urandom_range(1, 2 * DB + 4);
      end
      rst_r   = ($urandom_range(0, 299) == 0);
      rd_r    = ($urandom_range(0, 2) == 0);
      wr_r    = ($urandom_range(0, 3) == 0);
      addr_r  = 3'($urandom_range(0, 7));
      wdata_r = $urandom;
      tick();
    end
    rst_r = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
